mem_arbiter: RTL

//  Two-master to one-slave Avalon-MM arbiter in front of mem_if. Master 0 is the

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter: round-robin grant with optional
// per-master lock, bounded by MAX_BURST completions when the other master waits.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int MAX_BURST   = 8,
   parameter int BURST_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [BE_WIDTH-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_WIDTH-1:0] m0_writedata,
   input  logic                  m0_lock,
   output logic [DATA_WIDTH-1:0] m0_readdata,
   output logic                  m0_waitrequest,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [BE_WIDTH-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_WIDTH-1:0] m1_writedata,
   input  logic                  m1_lock,
   output logic [DATA_WIDTH-1:0] m1_readdata,
   output logic                  m1_waitrequest,
   output logic [ADDR_WIDTH-1:0] s_address,
   output logic [BE_WIDTH-1:0]   s_byteenable,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_WIDTH-1:0] s_writedata,
   input  logic [DATA_WIDTH-1:0] s_readdata,
   input  logic                  s_waitrequest,
   output logic [1:0]            grant,
   output logic [1:0]            dbg_state
);

   // Handshake: a transfer completes in any cycle where the granted master holds
   // read or write high and waitrequest is low; the master must keep its command
   // and data stable while waitrequest is high.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [BURST_WIDTH-1:0] BURST_LAST = BURST_WIDTH'(MAX_BURST - 1);

   state_t                 state;
   logic                   last_grant;
   logic [BURST_WIDTH-1:0] burst_cnt;

   logic req0, req1;
   logic cur_req, cur_lock, oth_req;
   logic done, at_limit, release_now;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   always_comb begin
      cur_req  = 1'b0;
      cur_lock = 1'b0;
      oth_req  = 1'b0;
      case (state)
         GNT0: begin
            cur_req  = req0;
            cur_lock = m0_lock;
            oth_req  = req1;
         end
         GNT1: begin
            cur_req  = req1;
            cur_lock = m1_lock;
            oth_req  = req0;
         end
         default: ;
      endcase
   end

   assign done        = cur_req & ~s_waitrequest;
   assign at_limit    = (burst_cnt == BURST_LAST);
   // Forced release only matters when locked; an unlocked master leaves on done or idle.
   assign release_now = (done & ~cur_lock)
                      | (~cur_req & ~cur_lock)
                      | (done & cur_lock & oth_req & at_limit);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         burst_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (req0 & (~req1 | last_grant))
                  state <= GNT0;
               else if (req1)
                  state <= GNT1;
            end
            GNT0: begin
               if (release_now) begin
                  last_grant <= 1'b0;
                  burst_cnt  <= '0;
                  state      <= oth_req ? GNT1 : IDLE;
               end else if (done && !at_limit) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            GNT1: begin
               if (release_now) begin
                  last_grant <= 1'b1;
                  burst_cnt  <= '0;
                  state      <= oth_req ? GNT0 : IDLE;
               end else if (done && !at_limit) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // Slave strobes decode straight from state so an async reset drops them at once.
   always_comb begin
      s_address      = '0;
      s_byteenable   = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      grant          = 2'b00;
      case (state)
         GNT0: begin
            s_address      = m0_address;
            s_byteenable   = m0_byteenable;
            s_read         = m0_read;
            s_write        = m0_write;
            s_writedata    = m0_writedata;
            m0_waitrequest = s_waitrequest;
            grant          = 2'b01;
         end
         GNT1: begin
            s_address      = m1_address;
            s_byteenable   = m1_byteenable;
            s_read         = m1_read;
            s_write        = m1_write;
            s_writedata    = m1_writedata;
            m1_waitrequest = s_waitrequest;
            grant          = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;
   assign dbg_state   = state;

endmodule
